serial_bit_feeder: RTL and testbench

- Parallel-to-serial stage directly upstream of the 0110 sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit at a time.
- Drives the detector's data_in from bit_out and its en from bit_en.
- Back-to-back words stream with no gap bits, so a pattern that spans a word boundary is presented contiguously.

---
 rtl/serial_feeder_pkg.sv | 20 ++
 rtl/bit_period_divider.sv | 42 ++++
 rtl/serial_bit_feeder.sv | 124 ++++++++++++
 tb/tb_serial_bit_feeder.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/serial_feeder_pkg.sv
// rtl/serial_feeder_pkg.sv - shared types and sizing helpers for the serial bit feeder
// Macro SERIAL_BIT_FEEDER_PARITY_EN adds one even-parity bit per word to NBITS.
package serial_feeder_pkg;

  localparam int STATE_W = 1;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic int calc_nbits(input int width);
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/bit_period_divider.sv
// rtl/bit_period_divider.sv - counts 0..BIT_PERIOD-1 and flags the first/last cycle of a bit
// last_next_o looks one cycle ahead so callers can register outputs that depend on the wrap.
module bit_period_divider #(
  parameter int BIT_PERIOD = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic first_o,
  output logic last_o,
  output logic last_next_o
);

  localparam int CNT_W = $clog2(BIT_PERIOD + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_PERIOD - 1);

  logic [CNT_W-1:0] div_cnt_q;
  logic [CNT_W-1:0] div_cnt_d;

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (clear_i) begin
      div_cnt_d = '0;
    end else if (en_i) begin
      div_cnt_d = (div_cnt_q == LAST_CNT) ? '0 : div_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  assign first_o     = (div_cnt_q == '0);
  assign last_o      = (div_cnt_q == LAST_CNT);
  assign last_next_o = (div_cnt_d == LAST_CNT);

endmodule

// File: rtl/serial_bit_feeder.sv
// rtl/serial_bit_feeder.sv - serialises WIDTH-bit words onto bit_out/bit_en with zero-gap streaming
// Macro SERIAL_BIT_FEEDER_PARITY_EN appends an even-parity bit after the data bits.
module serial_bit_feeder
  import serial_feeder_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int BIT_PERIOD = 1,
  parameter int MSB_FIRST  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             bit_out,
  output logic             bit_en,
  output logic             busy,
  output logic             frame_done
);

  localparam int NBITS  = calc_nbits(WIDTH);
  localparam int BCNT_W = $clog2(NBITS + 1);
  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(NBITS - 1);

  state_e            state_q, state_d;
  logic [NBITS-1:0]  shreg_q, shreg_d, load_word, shifted;
  logic [BCNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic              bit_out_q, bit_en_q, busy_q, frame_done_q;
  logic              div_clear, div_en, div_first, div_last, div_last_next;
  logic              accept, head_d, bit_en_d, frame_done_d;

`ifdef SERIAL_BIT_FEEDER_PARITY_EN
  logic parity;
  assign parity    = ^in_data;
  assign load_word = (MSB_FIRST != 0) ? {in_data, parity} : {parity, in_data};
`else
  assign load_word = in_data;
`endif

  assign shifted = (MSB_FIRST != 0) ? {shreg_q[NBITS-2:0], 1'b0} : {1'b0, shreg_q[NBITS-1:1]};
  assign head_d  = (MSB_FIRST != 0) ? shreg_d[NBITS-1] : shreg_d[0];

  // frame_done_q marks the last cycle of a word, which is also the only SHIFT cycle open for a new word.
  assign in_ready = !reset && ((state_q == IDLE) || frame_done_q);
  assign accept   = in_valid && in_ready;

  bit_period_divider #(
    .BIT_PERIOD(BIT_PERIOD)
  ) u_div (
    .clk_i      (clk),
    .rst_i      (reset),
    .clear_i    (div_clear),
    .en_i       (div_en),
    .first_o    (div_first),
    .last_o     (div_last),
    .last_next_o(div_last_next)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    div_clear = 1'b0;
    div_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d   = load_word;
          bit_cnt_d = '0;
          div_clear = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        div_en = 1'b1;
        if (frame_done_q) begin
          div_clear = 1'b1;
          bit_cnt_d = '0;
          if (accept) begin
            shreg_d = load_word;
          end else begin
            shreg_d = '0;
            state_d = IDLE;
          end
        end else if (div_last) begin
          shreg_d   = shifted;
          bit_cnt_d = bit_cnt_q + BCNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  assign bit_en_d     = (state_d == SHIFT) &&
                        (div_clear || (div_en && div_last) || (!div_en && div_first));
  assign frame_done_d = (state_d == SHIFT) && (bit_cnt_d == LAST_BIT) && div_last_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      bit_out_q    <= 1'b0;
      bit_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      bit_out_q    <= (state_d == SHIFT) && head_d;
      bit_en_q     <= bit_en_d;
      busy_q       <= (state_d == SHIFT);
      frame_done_q <= frame_done_d;
    end
  end

  assign bit_out    = bit_out_q;
  assign bit_en     = bit_en_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// tb/tb_serial_bit_feeder.sv - directed bench for serial_bit_feeder (three configurations)
// Parity expectations follow SERIAL_BIT_FEEDER_PARITY_EN when it is defined.
module tb_serial_bit_feeder;

`ifdef SERIAL_BIT_FEEDER_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data  [3];
  logic       in_valid [3];
  logic       in_ready [3];
  logic       bit_out  [3];
  logic       bit_en   [3];
  logic       busy     [3];
  logic       frame_done [3];

  int checks = 0;
  int errors = 0;

  logic [3:0] hist;
  logic       det_seen;

  always #5 clk = ~clk;

  serial_bit_feeder #(.WIDTH(8), .BIT_PERIOD(1), .MSB_FIRST(1)) dut0 (
    .clk(clk), .reset(reset), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .bit_out(bit_out[0]), .bit_en(bit_en[0]),
    .busy(busy[0]), .frame_done(frame_done[0]));

  serial_bit_feeder #(.WIDTH(8), .BIT_PERIOD(3), .MSB_FIRST(1)) dut1 (
    .clk(clk), .reset(reset), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .bit_out(bit_out[1]), .bit_en(bit_en[1]),
    .busy(busy[1]), .frame_done(frame_done[1]));

  serial_bit_feeder #(.WIDTH(8), .BIT_PERIOD(1), .MSB_FIRST(0)) dut2 (
    .clk(clk), .reset(reset), .in_data(in_data[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .bit_out(bit_out[2]), .bit_en(bit_en[2]),
    .busy(busy[2]), .frame_done(frame_done[2]));

  // Stand-in for the downstream 0110 detector on dut0.
  always @(posedge clk) begin
    if (reset) begin
      hist     <= 4'b0;
      det_seen <= 1'b0;
    end else if (bit_en[0]) begin
      hist <= {hist[2:0], bit_out[0]};
      if ({hist[2:0], bit_out[0]} == 4'b0110) det_seen <= 1'b1;
    end
  end

  task automatic check(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, idx, obs, exp);
    end
  endtask

  // seq lists the data bits in emission order, leftmost first; par is the parity bit.
  task automatic run_word(input int d, input logic [7:0] data, input logic [7:0] seq,
                          input logic par, input int period, input string tag);
    int   total;
    int   b;
    logic eb;
    total = NB * period;
    @(negedge clk);
    check({tag, ".ready_idle"}, 0, in_ready[d], 1'b1);
    in_data[d]  = data;
    in_valid[d] = 1'b1;
    @(negedge clk);
    in_valid[d] = 1'b0;
    for (int i = 0; i < total; i++) begin
      b  = i / period;
      eb = (b < 8) ? seq[7-b] : par;
      check({tag, ".bit_out"}, i, bit_out[d], eb);
      check({tag, ".bit_en"}, i, bit_en[d], (i % period) == 0);
      check({tag, ".busy"}, i, busy[d], 1'b1);
      check({tag, ".frame_done"}, i, frame_done[d], i == total - 1);
      check({tag, ".in_ready"}, i, in_ready[d], i == total - 1);
      @(negedge clk);
    end
    check({tag, ".busy_after"}, 0, busy[d], 1'b0);
    check({tag, ".bit_out_after"}, 0, bit_out[d], 1'b0);
    check({tag, ".frame_done_after"}, 0, frame_done[d], 1'b0);
  endtask

  initial begin
    int         fd_count;
    int         b;
    logic [7:0] seq;
    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      in_data[d]  = 8'h00;
      in_valid[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("rst.in_ready", d, in_ready[d], 1'b0);
      check("rst.busy", d, busy[d], 1'b0);
      check("rst.bit_out", d, bit_out[d], 1'b0);
      check("rst.bit_en", d, bit_en[d], 1'b0);
      check("rst.frame_done", d, frame_done[d], 1'b0);
    end
    reset = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) check("post_rst.in_ready", d, in_ready[d], 1'b1);

    // Single word feeding the detector.
    run_word(0, 8'h60, 8'b0110_0000, 1'b0, 1, "single");
    check("detector", 0, det_seen, 1'b1);

    // Back-to-back words with in_valid held high.
    @(negedge clk);
    in_data[0]  = 8'h01;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_data[0] = 8'h10;
    for (int i = 0; i < 2 * NB; i++) begin
      b   = i % NB;
      seq = (i < NB) ? 8'b0000_0001 : 8'b0001_0000;
      if (i == 2 * NB - 1) in_valid[0] = 1'b0;
      check("b2b.bit_out", i, bit_out[0], (b < 8) ? seq[7-b] : 1'b1);
      check("b2b.bit_en", i, bit_en[0], 1'b1);
      check("b2b.busy", i, busy[0], 1'b1);
      check("b2b.in_ready", i, in_ready[0], b == NB - 1);
      check("b2b.frame_done", i, frame_done[0], b == NB - 1);
      @(negedge clk);
    end
    check("b2b.busy_after", 0, busy[0], 1'b0);

    run_word(1, 8'hA5, 8'b1010_0101, 1'b0, 3, "period3");
    run_word(2, 8'h06, 8'b0110_0000, 1'b0, 1, "lsb_first");

    // Reset in the middle of a word.
    @(negedge clk);
    in_data[0]  = 8'hFF;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("abort.bit_out", i, bit_out[0], 1'b1);
      check("abort.busy", i, busy[0], 1'b1);
      @(negedge clk);
    end
    check("abort.bit3", 3, bit_out[0], 1'b1);
    #1 reset = 1'b1;
    #1;
    check("abort.async.bit_out", 0, bit_out[0], 1'b0);
    check("abort.async.bit_en", 0, bit_en[0], 1'b0);
    check("abort.async.busy", 0, busy[0], 1'b0);
    check("abort.async.frame_done", 0, frame_done[0], 1'b0);
    check("abort.async.in_ready", 0, in_ready[0], 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort.release.in_ready", 0, in_ready[0], 1'b1);
    fd_count = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (frame_done[0]) fd_count++;
    end
    check("abort.no_frame_done", 0, fd_count, 0);
    check("abort.idle_busy", 0, busy[0], 1'b0);
    run_word(0, 8'h60, 8'b0110_0000, 1'b0, 1, "after_abort");

`ifdef SERIAL_BIT_FEEDER_PARITY_EN
    run_word(0, 8'h07, 8'b0000_0111, 1'b1, 1, "parity");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
